// File: rtl/alu_seq_defs.sv
// Shared encodings for the ALU sequencer: request op codes, ALU Oper codes,
// FSM states and operand-source selects.
package alu_seq_defs;

  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpSub  = 4'b0001,
    OpAnd  = 4'b0010,
    OpOr   = 4'b0011,
    OpXor  = 4'b0100,
    OpAndn = 4'b0101,
    OpSeq  = 4'b0110,
    OpSlt  = 4'b0111,
    OpSle  = 4'b1000,
    OpRol  = 4'b1001,
    OpRor  = 4'b1010,
    OpBtr  = 4'b1011,
    OpSlbi = 4'b1100
  } req_op_e;

  typedef enum logic [3:0] {
    AluRol = 4'b0000,
    AluAdd = 4'b0100,
    AluAnd = 4'b0101,
    AluOr  = 4'b0110,
    AluXor = 4'b0111,
    AluSll = 4'b1000,
    AluBtr = 4'b1001,
    AluRor = 4'b1010
  } alu_oper_e;

  typedef enum logic [1:0] {
    StIdle,
    StPass1,
    StPass2,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    OpndAB,
    OpndAShift8,
    OpndTmpImm
  } opnd_sel_e;

  // SLBI first pass shifts A left by this amount through the ALU shifter.
  localparam logic [15:0] SlbiShift = 16'd8;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational map from (request op, pass) to ALU controls, operand source,
// pass count and illegal-op flag.
module alu_seq_decode
  import alu_seq_defs::*;
(
  input  logic [3:0] op,
  input  logic       pass2,
  output logic [3:0] oper,
  output logic       cin,
  output logic       inv_a,
  output logic       inv_b,
  output logic       sign,
  output logic [1:0] opnd_sel,
  output logic       two_pass,
  output logic       illegal
);

  always_comb begin
    oper     = AluAdd;
    cin      = 1'b0;
    inv_a    = 1'b0;
    inv_b    = 1'b0;
    sign     = 1'b0;
    opnd_sel = OpndAB;
    two_pass = 1'b0;
    illegal  = 1'b0;
    case (op)
      OpAdd: sign = 1'b1;
      // SUB computes B - A as ~A + B + 1.
      OpSub, OpSlt: begin
        inv_a = 1'b1;
        cin   = 1'b1;
        sign  = 1'b1;
      end
      OpAnd:        oper = AluAnd;
      OpOr:         oper = AluOr;
      OpXor, OpSeq: oper = AluXor;
      OpAndn: begin
        oper  = AluAnd;
        inv_b = 1'b1;
      end
      OpSle: begin
        two_pass = 1'b1;
        if (!pass2) begin
          oper = AluXor;
        end else begin
          inv_a = 1'b1;
          cin   = 1'b1;
          sign  = 1'b1;
        end
      end
      OpRol: oper = AluRol;
      OpRor: oper = AluRor;
      OpBtr: oper = AluBtr;
      OpSlbi: begin
        two_pass = 1'b1;
        if (!pass2) begin
          oper     = AluSll;
          opnd_sel = OpndAShift8;
        end else begin
          oper     = AluOr;
          opnd_sel = OpndTmpImm;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences compound ops over an external combinational ALU in one or two
// passes and returns the result through a valid/ready response port.
module alu_sequencer
  import alu_seq_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [15:0] alu_InA,
  output logic [15:0] alu_InB,
  output logic [3:0]  alu_Oper,
  output logic        alu_Cin,
  output logic        alu_invA,
  output logic        alu_invB,
  output logic        alu_sign,
  input  logic [15:0] alu_Out,
  input  logic        alu_Zero,
  input  logic        alu_Ofl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_ofl,
  output logic        rsp_zero,
  output logic        rsp_err
);

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] a_q, a_d, b_q, b_d, tmp_q, tmp_d;
  logic        eq_q, eq_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_ofl_q, rsp_ofl_d, rsp_zero_q, rsp_zero_d, rsp_err_q, rsp_err_d;

  logic [3:0]  dec_op, dec_oper;
  logic [1:0]  dec_opnd_sel;
  logic        dec_cin, dec_inv_a, dec_inv_b, dec_sign, dec_two_pass, dec_illegal;
  logic        lt;
  logic [15:0] res_data;
  logic        res_ofl;

  // In IDLE the decoder looks at the offered op so illegal ones can skip the passes.
  assign dec_op = (state_q == StIdle) ? req_op : op_q;

  alu_seq_decode u_decode (
    .op       (dec_op),
    .pass2    (state_q == StPass2),
    .oper     (dec_oper),
    .cin      (dec_cin),
    .inv_a    (dec_inv_a),
    .inv_b    (dec_inv_b),
    .sign     (dec_sign),
    .opnd_sel (dec_opnd_sel),
    .two_pass (dec_two_pass),
    .illegal  (dec_illegal)
  );

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_ofl   = rsp_ofl_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    alu_InA  = '0;
    alu_InB  = '0;
    alu_Oper = AluAdd;
    alu_Cin  = 1'b0;
    alu_invA = 1'b0;
    alu_invB = 1'b0;
    alu_sign = 1'b0;
    if (state_q == StPass1 || state_q == StPass2) begin
      alu_Oper = dec_oper;
      alu_Cin  = dec_cin;
      alu_invA = dec_inv_a;
      alu_invB = dec_inv_b;
      alu_sign = dec_sign;
      case (dec_opnd_sel)
        OpndAShift8: begin
          alu_InA = a_q;
          alu_InB = SlbiShift;
        end
        OpndTmpImm: begin
          alu_InA = tmp_q;
          alu_InB = {8'h00, b_q[7:0]};
        end
        default: begin
          alu_InA = a_q;
          alu_InB = b_q;
        end
      endcase
    end
  end

  // Signed A < B from the B - A pass: strictly positive difference.
  assign lt = ~alu_Zero & ~(alu_Out[15] ^ alu_Ofl);

  always_comb begin
    res_data = alu_Out;
    case (op_q)
      OpSeq:   res_data = {15'b0, alu_Zero};
      OpSlt:   res_data = {15'b0, lt};
      OpSle:   res_data = {15'b0, eq_q | lt};
      default: res_data = alu_Out;
    endcase
    res_ofl = (op_q == OpAdd || op_q == OpSub) & alu_Ofl;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    tmp_d      = tmp_q;
    eq_d       = eq_q;
    rsp_data_d = rsp_data_q;
    rsp_ofl_d  = rsp_ofl_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          if (dec_illegal) begin
            state_d    = StResp;
            rsp_data_d = '0;
            rsp_ofl_d  = 1'b0;
            rsp_zero_d = 1'b1;
            rsp_err_d  = 1'b1;
          end else begin
            state_d = StPass1;
          end
        end
      end
      StPass1, StPass2: begin
        if (state_q == StPass1 && dec_two_pass) begin
          tmp_d   = alu_Out;
          eq_d    = alu_Zero;
          state_d = StPass2;
        end else begin
          rsp_data_d = res_data;
          rsp_ofl_d  = res_ofl;
          rsp_zero_d = (res_data == '0);
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tmp_q      <= '0;
      eq_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_ofl_q  <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tmp_q      <= tmp_d;
      eq_q       <= eq_d;
      rsp_data_q <= rsp_data_d;
      rsp_ofl_q  <= rsp_ofl_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: external ALU model, directed vector table, handshake
// and reset sequences, then random ops against an arithmetic reference model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [15:0] alu_InA, alu_InB, alu_Out;
  logic [3:0]  alu_Oper;
  logic        alu_Cin, alu_invA, alu_invB, alu_sign, alu_Zero, alu_Ofl;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_ofl, rsp_zero, rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_InA   (alu_InA),
    .alu_InB   (alu_InB),
    .alu_Oper  (alu_Oper),
    .alu_Cin   (alu_Cin),
    .alu_invA  (alu_invA),
    .alu_invB  (alu_invB),
    .alu_sign  (alu_sign),
    .alu_Out   (alu_Out),
    .alu_Zero  (alu_Zero),
    .alu_Ofl   (alu_Ofl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ofl   (rsp_ofl),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err)
  );

  // External ALU: operand inversion, then the Oper-selected function.
  logic [15:0] alu_x, alu_y;
  logic [16:0] alu_sum;
  logic [31:0] alu_wide;
  always_comb begin
    alu_x    = alu_invA ? ~alu_InA : alu_InA;
    alu_y    = alu_invB ? ~alu_InB : alu_InB;
    alu_sum  = {1'b0, alu_x} + {1'b0, alu_y} + {16'b0, alu_Cin};
    alu_wide = '0;
    alu_Out  = '0;
    alu_Ofl  = 1'b0;
    case (alu_Oper)
      4'b0100: begin
        alu_Out = alu_sum[15:0];
        alu_Ofl = alu_sign ? ((alu_x[15] == alu_y[15]) && (alu_sum[15] != alu_x[15]))
                           : alu_sum[16];
      end
      4'b0101: alu_Out = alu_x & alu_y;
      4'b0110: alu_Out = alu_x | alu_y;
      4'b0111: alu_Out = alu_x ^ alu_y;
      4'b0000: begin
        alu_wide = {alu_x, alu_x} << alu_y[3:0];
        alu_Out  = alu_wide[31:16];
      end
      4'b1010: begin
        alu_wide = {alu_x, alu_x} >> alu_y[3:0];
        alu_Out  = alu_wide[15:0];
      end
      4'b1001: for (int i = 0; i < 16; i++) alu_Out[i] = alu_x[15-i];
      4'b1000: alu_Out = alu_x << alu_y[3:0];
      default: alu_Out = '0;
    endcase
    alu_Zero = (alu_Out == 16'h0000);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference result of a compound op, from its arithmetic meaning.
  function automatic void ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] d, output logic ofl, output logic zero,
                                    output logic err, output int lat);
    int sa, sb, s;
    sa  = $signed(a);
    sb  = $signed(b);
    s   = 0;
    d   = '0;
    ofl = 1'b0;
    err = 1'b0;
    lat = 2;
    case (op)
      4'd0: begin s = sa + sb; d = s[15:0]; ofl = (s > 32767) || (s < -32768); end
      4'd1: begin s = sb - sa; d = s[15:0]; ofl = (s > 32767) || (s < -32768); end
      4'd2: d = a & b;
      4'd3: d = a | b;
      4'd4: d = a ^ b;
      4'd5: d = a & ~b;
      4'd6: d = {15'b0, a == b};
      4'd7: d = {15'b0, sa < sb};
      4'd8: begin d = {15'b0, sa <= sb}; lat = 3; end
      4'd9: begin d = a; for (int i = 0; i < int'(b[3:0]); i++) d = {d[14:0], d[15]}; end
      4'd10: begin d = a; for (int i = 0; i < int'(b[3:0]); i++) d = {d[0], d[15:1]}; end
      4'd11: for (int i = 0; i < 16; i++) d[i] = a[15-i];
      4'd12: begin d = (a << 8) | {8'h00, b[7:0]}; lat = 3; end
      default: begin err = 1'b1; lat = 1; end
    endcase
    zero = (d == 16'h0000);
  endfunction

  // One transaction from IDLE: offer, measure latency, check response, optional stall.
  task automatic do_txn(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] e_data, input logic e_ofl,
                        input logic e_zero, input logic e_err, input int e_lat, input int stall);
    int lat;
    rsp_ready = (stall == 0);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, lat, e_lat);
    chk({tag, " data"}, rsp_data, e_data);
    chk({tag, " ofl"}, rsp_ofl, e_ofl);
    chk({tag, " zero"}, rsp_zero, e_zero);
    chk({tag, " err"}, rsp_err, e_err);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " stall hold"}, {rsp_valid, req_ready, rsp_data}, {1'b1, 1'b0, e_data});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " back to idle"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        ofl;
    logic        zero;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [15:0] rd;
    logic        ro, rz, re;
    int          rl, lat;
    logic [3:0]  op;
    logic [15:0] a, b;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", req_ready, 1'b1);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp fields", {rsp_data, rsp_ofl, rsp_zero, rsp_err}, 19'h0);
    chk("reset alu drive", {alu_InA, alu_InB, alu_Oper, alu_Cin, alu_invA, alu_invB, alu_sign},
        {32'h0, 4'b0100, 4'b0000});
    rst = 1'b0;

    vecs.push_back('{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h1, 16'h0003, 16'h0010, 16'h000D, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h7, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h8, 16'h0005, 16'h0005, 16'h0001, 1'b0, 1'b0, 1'b0, 3});
    vecs.push_back('{4'h8, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 3});
    vecs.push_back('{4'hC, 16'h12AB, 16'h00CD, 16'hABCD, 1'b0, 1'b0, 1'b0, 3});
    vecs.push_back('{4'hE, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b1, 1});
    vecs.push_back('{4'h6, 16'h1234, 16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h5, 16'hF0F0, 16'hFF00, 16'h00F0, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h9, 16'h8001, 16'h0001, 16'h0003, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'hA, 16'h8001, 16'h0001, 16'hC000, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'hB, 16'h0001, 16'h5555, 16'h8000, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h4, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 2});
    vecs.push_back('{4'h3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2});
    vecs.push_back('{4'h1, 16'h0001, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 2});
    foreach (vecs[i])
      do_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].data,
             vecs[i].ofl, vecs[i].zero, vecs[i].err, vecs[i].lat, 0);

    // Stalled ADD; a competing request waits out the stall and the handshake edge.
    rsp_ready = 1'b0;
    req_op = 4'h0; req_a = 16'h0001; req_b = 16'h0002; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_op = 4'h1; req_a = 16'h0005; req_b = 16'h0009;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("stall add latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall add hold", {rsp_valid, req_ready, rsp_data, rsp_ofl, rsp_err},
          {2'b10, 16'h0003, 2'b00});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("handshake edge no accept", {rsp_valid, req_ready}, 2'b01);
    @(posedge clk);
    #1;
    chk("accept after handshake", req_ready, 1'b0);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("competing sub latency", lat, 2);
    chk("competing sub data", rsp_data, 16'h0004);
    @(posedge clk);
    #1;

    // Reset while SLE is in its second pass.
    req_op = 4'h8; req_a = 16'h0005; req_b = 16'h0005; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid reset req_ready", req_ready, 1'b1);
    chk("mid reset rsp_valid", rsp_valid, 1'b0);
    chk("mid reset rsp fields", {rsp_data, rsp_ofl, rsp_zero, rsp_err}, 19'h0);
    chk("mid reset alu oper", {alu_Oper, alu_InA}, {4'b0100, 16'h0000});
    do_txn("post reset illegal", 4'hE, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b1, 1'b1, 1, 0);

    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (n % 4 == 0) b = a;
      ref_model(op, a, b, rd, ro, rz, re, rl);
      do_txn($sformatf("rand%0d op%0h", n, op), op, a, b, rd, ro, rz, re, rl,
             int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
